// File: rtl/mem_alloc_arbiter.sv
// mem_alloc_arbiter
//   Shares one mem_manager block allocator between NPORT write engines.
//   Allocation: round-robin grant, then a single ocp_req/ocp_rsp handshake
//   with the mem_manager; the returned block address goes to the winner.
//   Release: an independent round-robin serialiser that forwards one
//   release per cycle onto the mem_manager rls channel.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   alloc_req[NPORT]    per-port allocation request (level)
//   alloc_vld[NPORT]    one-hot, one-cycle allocation-done pulse
//   alloc_addr          allocated block address (valid with alloc_vld)
//   alloc_busy          grant outstanding
//   rls_req[NPORT]      per-port release request (level)
//   rls_addr            packed per-port release addresses
//   rls_ack[NPORT]      one-hot, one-cycle release-accepted pulse
//   mm_ocp_*            allocation handshake with mem_manager
//   mm_full             mem_manager has no free block
//   mm_rls_vld/addr     release channel to mem_manager

// Round-robin picker: first set bit of req at or after ptr, wrapping.
module mem_alloc_rr_pick #(
    parameter int NPORT = 4,
    parameter int PW    = 2
) (
    input  logic [NPORT-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic             any,
    output logic [PW-1:0]    idx
);
    logic [PW:0]   s;
    logic [PW-1:0] pi;

    // Scan from the far end back towards ptr so the closest candidate
    // is the last one written.
    always_comb begin
        any = 1'b0;
        idx = '0;
        s   = '0;
        pi  = '0;
        for (int k = NPORT - 1; k >= 0; k--) begin
            s = {1'b0, ptr} + (PW+1)'(k);
            if (s >= (PW+1)'(NPORT)) s = s - (PW+1)'(NPORT);
            pi = s[PW-1:0];
            if (req[pi]) begin
                any = 1'b1;
                idx = pi;
            end
        end
    end
endmodule

module mem_alloc_arbiter #(
    parameter int NPORT  = 4,
    parameter int AWIDTH = 10,
    parameter int PW     = $clog2(NPORT)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NPORT-1:0]        alloc_req,
    output logic [NPORT-1:0]        alloc_vld,
    output logic [AWIDTH-1:0]       alloc_addr,
    output logic                    alloc_busy,
    input  logic [NPORT-1:0]        rls_req,
    input  logic [NPORT*AWIDTH-1:0] rls_addr,
    output logic [NPORT-1:0]        rls_ack,
    output logic                    mm_ocp_req,
    input  logic                    mm_ocp_rsp,
    input  logic [AWIDTH-1:0]       mm_ocp_addr,
    input  logic                    mm_ocp_vld,
    input  logic                    mm_full,
    output logic                    mm_rls_vld,
    output logic [AWIDTH-1:0]       mm_rls_addr
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    function automatic logic [NPORT-1:0] onehot(input logic [PW-1:0] i);
        onehot    = '0;
        onehot[i] = 1'b1;
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] i);
        ptr_inc = (int'(i) == NPORT - 1) ? '0 : i + 1'b1;
    endfunction

    // ---------------- allocation ----------------
    state_t              state, state_nxt;
    logic [PW-1:0]       alloc_ptr, alloc_ptr_nxt;
    logic [PW-1:0]       win, win_nxt;
    logic                ocp_req_nxt, busy_nxt;
    logic [NPORT-1:0]    vld_nxt;
    logic [AWIDTH-1:0]   addr_nxt;
    logic                a_any;
    logic [PW-1:0]       a_idx;

    mem_alloc_rr_pick #(.NPORT(NPORT), .PW(PW)) u_alloc_pick (
        .req (alloc_req),
        .ptr (alloc_ptr),
        .any (a_any),
        .idx (a_idx)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            alloc_ptr  <= '0;
            win        <= '0;
            mm_ocp_req <= 1'b0;
            alloc_busy <= 1'b0;
            alloc_vld  <= '0;
            alloc_addr <= '0;
        end else begin
            state      <= state_nxt;
            alloc_ptr  <= alloc_ptr_nxt;
            win        <= win_nxt;
            mm_ocp_req <= ocp_req_nxt;
            alloc_busy <= busy_nxt;
            alloc_vld  <= vld_nxt;
            alloc_addr <= addr_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        alloc_ptr_nxt = alloc_ptr;
        win_nxt       = win;
        ocp_req_nxt   = mm_ocp_req;
        busy_nxt      = alloc_busy;
        vld_nxt       = '0;
        addr_nxt      = '0;
        case (state)
            S_IDLE: begin
                // No grant while full: requests simply stay pending.
                if (a_any && !mm_full) begin
                    win_nxt     = a_idx;
                    ocp_req_nxt = 1'b1;
                    busy_nxt    = 1'b1;
                    state_nxt   = S_WAIT;
                end
            end
            S_WAIT: begin
                // No timeout and no cancel: a grant always completes, even
                // if the winner drops its request or mm_full rises.
                if (mm_ocp_rsp && mm_ocp_vld) begin
                    ocp_req_nxt   = 1'b0;
                    vld_nxt       = onehot(win);
                    addr_nxt      = mm_ocp_addr;
                    alloc_ptr_nxt = ptr_inc(win);
                    busy_nxt      = 1'b0;
                    state_nxt     = S_DONE;
                end
            end
            S_DONE: begin
                // One idle cycle with ocp_req low lets mem_manager return
                // to its idle state before the next grant.
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt   = S_IDLE;
                ocp_req_nxt = 1'b0;
                busy_nxt    = 1'b0;
            end
        endcase
    end

    // ---------------- release ----------------
    logic [AWIDTH-1:0] rls_addr_a [NPORT];
    logic [PW-1:0]     rls_ptr;
    logic [NPORT-1:0]  rls_mask;
    logic              r_any;
    logic [PW-1:0]     r_idx;

    for (genvar g = 0; g < NPORT; g++) begin : g_rls_addr
        assign rls_addr_a[g] = rls_addr[g*AWIDTH +: AWIDTH];
    end

    // A port whose ack is on the wire this cycle is still holding its
    // request; mask it so the same release is not forwarded twice.
    assign rls_mask = rls_req & ~rls_ack;

    mem_alloc_rr_pick #(.NPORT(NPORT), .PW(PW)) u_rls_pick (
        .req (rls_mask),
        .ptr (rls_ptr),
        .any (r_any),
        .idx (r_idx)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rls_ptr     <= '0;
            rls_ack     <= '0;
            mm_rls_vld  <= 1'b0;
            mm_rls_addr <= '0;
        end else if (r_any) begin
            rls_ptr     <= ptr_inc(r_idx);
            rls_ack     <= onehot(r_idx);
            mm_rls_vld  <= 1'b1;
            mm_rls_addr <= rls_addr_a[r_idx];
        end else begin
            rls_ack     <= '0;
            mm_rls_vld  <= 1'b0;
            mm_rls_addr <= '0;
        end
    end
endmodule

// File: tb/tb_mem_alloc_arbiter.sv
// Bench for mem_alloc_arbiter: a behavioural mem_manager, a transaction-level
// reference of the arbiter, directed scenarios with literal expectations and
// a randomized phase.
module tb_mem_alloc_arbiter;
    localparam int NPORT  = 4;
    localparam int AWIDTH = 10;
    localparam int DEPTH  = 1 << AWIDTH;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [NPORT-1:0]        alloc_req = '0;
    logic [NPORT-1:0]        alloc_vld;
    logic [AWIDTH-1:0]       alloc_addr;
    logic                    alloc_busy;
    logic [NPORT-1:0]        rls_req = '0;
    logic [NPORT*AWIDTH-1:0] rls_addr = '0;
    logic [NPORT-1:0]        rls_ack;
    logic                    mm_ocp_req;
    logic                    mm_ocp_rsp = 1'b0;
    logic [AWIDTH-1:0]       mm_ocp_addr = '0;
    logic                    mm_ocp_vld = 1'b0;
    logic                    mm_full = 1'b0;
    logic                    mm_rls_vld;
    logic [AWIDTH-1:0]       mm_rls_addr;

    int total = 0;
    int bad   = 0;

    mem_alloc_arbiter #(.NPORT(NPORT), .AWIDTH(AWIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_req(alloc_req), .alloc_vld(alloc_vld), .alloc_addr(alloc_addr),
        .alloc_busy(alloc_busy),
        .rls_req(rls_req), .rls_addr(rls_addr), .rls_ack(rls_ack),
        .mm_ocp_req(mm_ocp_req), .mm_ocp_rsp(mm_ocp_rsp), .mm_ocp_addr(mm_ocp_addr),
        .mm_ocp_vld(mm_ocp_vld), .mm_full(mm_full),
        .mm_rls_vld(mm_rls_vld), .mm_rls_addr(mm_rls_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- mem_manager model ----------------
    // Lowest free block first. ocp_rsp is asserted the cycle after it sees
    // ocp_req, and it drops for a cycle after every response.
    bit used [DEPTH];
    int n_used = 0;
    bit fill_req = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            foreach (used[i]) used[i] = 1'b0;
            n_used = 0;
            mm_ocp_rsp  <= 1'b0;
            mm_ocp_vld  <= 1'b0;
            mm_ocp_addr <= '0;
            mm_full     <= 1'b0;
        end else begin
            if (fill_req) begin
                foreach (used[i]) used[i] = 1'b1;
                n_used = DEPTH;
            end
            if (mm_rls_vld && used[mm_rls_addr]) begin
                used[mm_rls_addr] = 1'b0;
                n_used--;
            end
            if (mm_ocp_req && !mm_ocp_rsp) begin
                int f;
                f = -1;
                for (int i = 0; i < DEPTH; i++)
                    if (!used[i]) begin f = i; break; end
                mm_ocp_rsp <= 1'b1;
                if (f >= 0) begin
                    used[f] = 1'b1;
                    n_used++;
                    mm_ocp_vld  <= 1'b1;
                    mm_ocp_addr <= AWIDTH'(f);
                end else begin
                    mm_ocp_vld  <= 1'b0;
                end
            end else begin
                mm_ocp_rsp <= 1'b0;
                mm_ocp_vld <= 1'b0;
            end
            mm_full <= (n_used == DEPTH);
        end
    end

    // ---------------- reference model ----------------
    function automatic int rr(input logic [NPORT-1:0] r, input int ptr);
        for (int k = 0; k < NPORT; k++) begin
            int p;
            p = (ptr + k) % NPORT;
            if (r[p]) return p;
        end
        return -1;
    endfunction

    bit                model_on = 0;
    bit                m_inflight = 0, m_cool = 0;
    int                m_win = 0, m_aptr = 0, m_rptr = 0;
    logic [NPORT-1:0]  e_alloc_vld = '0, e_rls_ack = '0;
    logic [AWIDTH-1:0] e_alloc_addr = '0, e_rls_addr = '0;
    logic              e_busy = 0, e_ocp_req = 0, e_rls_vld = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            model_on = 1; m_inflight = 0; m_cool = 0; m_win = 0; m_aptr = 0; m_rptr = 0;
            e_alloc_vld = '0; e_alloc_addr = '0; e_busy = 0; e_ocp_req = 0;
            e_rls_ack = '0; e_rls_vld = 0; e_rls_addr = '0;
        end else begin
            int w;
            // release: one per cycle, skipping the port whose ack is current
            w = rr(rls_req & ~e_rls_ack, m_rptr);
            if (w >= 0) begin
                e_rls_ack  = '0; e_rls_ack[w] = 1'b1;
                e_rls_vld  = 1;
                e_rls_addr = rls_addr[w*AWIDTH +: AWIDTH];
                m_rptr     = (w + 1) % NPORT;
            end else begin
                e_rls_ack = '0; e_rls_vld = 0; e_rls_addr = '0;
            end
            // allocation
            e_alloc_vld = '0; e_alloc_addr = '0;
            if (m_inflight) begin
                if (mm_ocp_rsp && mm_ocp_vld) begin
                    e_alloc_vld[m_win] = 1'b1;
                    e_alloc_addr = mm_ocp_addr;
                    e_ocp_req = 0; e_busy = 0;
                    m_aptr = (m_win + 1) % NPORT;
                    m_inflight = 0; m_cool = 1;
                end
            end else if (m_cool) begin
                m_cool = 0;
            end else begin
                w = rr(alloc_req, m_aptr);
                if (w >= 0 && !mm_full) begin
                    m_win = w; m_inflight = 1; e_ocp_req = 1; e_busy = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            chk("alloc_vld", 32'(alloc_vld), 32'(e_alloc_vld));
            if (e_alloc_vld != 0) chk("alloc_addr", 32'(alloc_addr), 32'(e_alloc_addr));
            chk("alloc_busy", 32'(alloc_busy), 32'(e_busy));
            chk("mm_ocp_req", 32'(mm_ocp_req), 32'(e_ocp_req));
            chk("rls_ack", 32'(rls_ack), 32'(e_rls_ack));
            chk("mm_rls_vld", 32'(mm_rls_vld), 32'(e_rls_vld));
            if (e_rls_vld) chk("mm_rls_addr", 32'(mm_rls_addr), 32'(e_rls_addr));
        end
    end

    // ---------------- directed helpers ----------------
    task automatic do_reset();
        rst_n = 1'b0; alloc_req = '0; rls_req = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Waits for the next alloc_vld; lat counts negedges after the call,
    // hi counts cycles with mm_ocp_req high.
    task automatic wait_alloc(output int lat, output int hi,
                              output logic [NPORT-1:0] v, output logic [AWIDTH-1:0] a);
        lat = -1; hi = 0; v = '0; a = '0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (mm_ocp_req) hi++;
            if (alloc_vld != 0) begin lat = c; v = alloc_vld; a = alloc_addr; break; end
        end
    endtask

    int               lat, hi, n, c0;
    logic [NPORT-1:0] v, reraise;
    logic [AWIDTH-1:0] a;
    int               ports [5];
    int               addrs [5];
    logic [NPORT-1:0] acks [3];
    int               raddr [3];
    int               rcyc [3];
    bit               seen_rls;
    int               cnt;

    initial begin
        do_reset();
        chk("reset_alloc_vld", 32'(alloc_vld), 0);
        chk("reset_ocp_req", 32'(mm_ocp_req), 0);
        chk("reset_busy", 32'(alloc_busy), 0);
        chk("reset_rls_vld", 32'(mm_rls_vld), 0);

        // single request: alloc_vld in the 4th cycle counting the request cycle
        alloc_req = 4'b0001;
        wait_alloc(lat, hi, v, a);
        alloc_req = '0;
        chk("single_lat", lat, 3);
        chk("single_vld", 32'(v), 32'h1);
        chk("single_addr", 32'(a), 0);
        chk("single_ocp_hi", hi, 2);
        repeat (3) @(negedge clk);

        // fairness
        do_reset();
        alloc_req = 4'b1111; reraise = '0; n = 0;
        for (int c = 0; c < 200 && n < 5; c++) begin
            @(negedge clk);
            alloc_req |= reraise; reraise = '0;
            if (alloc_vld != 0) begin
                for (int i = 0; i < NPORT; i++) if (alloc_vld[i]) ports[n] = i;
                addrs[n] = int'(alloc_addr);
                n++;
                alloc_req &= ~alloc_vld;
                reraise = alloc_vld;
                if (n == 5) begin alloc_req = '0; reraise = '0; end
            end
        end
        alloc_req = '0;
        chk("fair_count", n, 5);
        for (int i = 0; i < 5 && i < n; i++) begin
            chk($sformatf("fair_port%0d", i), ports[i], i % NPORT);
            chk($sformatf("fair_addr%0d", i), addrs[i], i);
        end
        repeat (3) @(negedge clk);

        // release contention
        do_reset();
        rls_addr[0*AWIDTH +: AWIDTH] = 10;
        rls_addr[1*AWIDTH +: AWIDTH] = 11;
        rls_addr[2*AWIDTH +: AWIDTH] = 12;
        rls_req = 4'b0111; n = 0;
        for (int c = 1; c <= 20 && n < 3; c++) begin
            @(negedge clk);
            if (mm_rls_vld) begin
                acks[n] = rls_ack; raddr[n] = int'(mm_rls_addr); rcyc[n] = c; n++;
                rls_req &= ~rls_ack;
            end
        end
        rls_req = '0;
        chk("rls_count", n, 3);
        for (int i = 0; i < 3 && i < n; i++) begin
            v = '0; v[i] = 1'b1;
            chk($sformatf("rls_ack%0d", i), 32'(acks[i]), 32'(v));
            chk($sformatf("rls_addr%0d", i), raddr[i], 10 + i);
            chk($sformatf("rls_cyc%0d", i), rcyc[i], 1 + i);
        end
        repeat (3) @(negedge clk);

        // concurrent alloc (port 1) and release (port 2, addr 7)
        do_reset();
        alloc_req = 4'b0010; lat = -1; seen_rls = 0; a = '0; v = '0;
        for (int c = 1; c <= 40 && lat < 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                rls_addr[2*AWIDTH +: AWIDTH] = 7;
                rls_req = 4'b0100;
            end
            if (rls_ack != 0) begin
                seen_rls = (rls_ack == 4'b0100) && (mm_rls_addr == 7);
                rls_req = '0;
            end
            if (alloc_vld != 0) begin lat = c; v = alloc_vld; a = alloc_addr; end
        end
        alloc_req = '0;
        chk("conc_lat", lat, 3);
        chk("conc_vld", 32'(v), 32'h2);
        chk("conc_rls", 32'(seen_rls), 1);
        repeat (3) @(negedge clk);

        // full: no grant, then a release of block 5 drains it
        do_reset();
        fill_req = 1; @(negedge clk); fill_req = 0;
        repeat (2) @(negedge clk);
        chk("full_flag", 32'(mm_full), 1);
        alloc_req = 4'b0100; cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (mm_ocp_req || alloc_vld != 0) cnt++;
        end
        chk("full_no_grant", cnt, 0);
        rls_addr[3*AWIDTH +: AWIDTH] = 5;
        rls_req = 4'b1000;
        @(negedge clk);
        chk("full_rls_ack", 32'(rls_ack), 32'h8);
        rls_req = '0;
        wait_alloc(lat, hi, v, a);
        alloc_req = '0;
        chk("full_alloc_vld", 32'(v), 32'h4);
        chk("full_alloc_addr", 32'(a), 5);
        repeat (3) @(negedge clk);

        // reset while in WAIT
        do_reset();
        alloc_req = 4'b0100;
        @(negedge clk);
        chk("rstw_in_wait", 32'(mm_ocp_req), 1);
        rst_n = 1'b0; alloc_req = '0;
        @(negedge clk);
        chk("rstw_ocp_req", 32'(mm_ocp_req), 0);
        chk("rstw_busy", 32'(alloc_busy), 0);
        chk("rstw_vld", 32'(alloc_vld), 0);
        rst_n = 1'b1; alloc_req = 4'b0001;
        wait_alloc(lat, hi, v, a);
        alloc_req = '0;
        chk("rstw_lat", lat, 3);
        chk("rstw_port", 32'(v), 32'h1);
        chk("rstw_addr", 32'(a), 0);
        chk("rstw_ocp_hi", hi, 2);
        repeat (3) @(negedge clk);

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 599) == 0) begin
                rst_n = 1'b0; alloc_req = '0; rls_req = '0;
                continue;
            end
            for (int i = 0; i < NPORT; i++) begin
                if (alloc_vld[i]) alloc_req[i] = ($urandom_range(0, 3) == 0);
                else if (!alloc_req[i]) alloc_req[i] = ($urandom_range(0, 2) == 0);
                if (rls_ack[i]) begin
                    if ($urandom_range(0, 2) == 0)
                        rls_addr[i*AWIDTH +: AWIDTH] = AWIDTH'($urandom_range(0, DEPTH-1));
                    else
                        rls_req[i] = 1'b0;
                end else if (!rls_req[i] && $urandom_range(0, 2) == 0) begin
                    rls_addr[i*AWIDTH +: AWIDTH] = AWIDTH'($urandom_range(0, DEPTH-1));
                    rls_req[i] = 1'b1;
                end
            end
        end
        rst_n = 1'b1; alloc_req = '0; rls_req = '0;
        repeat (10) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_alloc_arbiter.md
Name: mem_alloc_arbiter

Overview:
- Shares one mem_manager block allocator between NPORT input-port write engines in the multi-port cache.
- Arbitrates allocation requests round-robin and sequences the mem_manager ocp_req/ocp_rsp handshake.
- Returns each allocated block address to the winning port.
- Independently serialises block-release requests from all ports onto the single rls_vld/rls_block_addr channel.

Parameters:
- NPORT, 4, number of requesting ports (2..16).
- AWIDTH, 10, block address width; matches mem_manager.
- PW, $clog2(NPORT), port index width (derived).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- alloc_req  in  NPORT  per-port allocation request; level, held until alloc_vld for that port.
- alloc_vld  out  NPORT  one-hot, one-cycle pulse: allocation done for that port.
- alloc_addr  out  AWIDTH  allocated block address; valid only while alloc_vld != 0.
- alloc_busy  out  1  high from grant until alloc_vld.
- rls_req  in  NPORT  per-port release request; level, held until rls_ack for that port.
- rls_addr  in  NPORT*AWIDTH  per-port release address; port i in bits [i*AWIDTH +: AWIDTH].
- rls_ack  out  NPORT  one-hot, one-cycle pulse: release accepted.
- mm_ocp_req  out  1  to mem_manager ocp_req.
- mm_ocp_rsp  in  1  from mem_manager ocp_rsp.
- mm_ocp_addr  in  AWIDTH  from mem_manager ocp_block_addr.
- mm_ocp_vld  in  1  from mem_manager ocp_vld.
- mm_full  in  1  from mem_manager full.
- mm_rls_vld  out  1  to mem_manager rls_vld.
- mm_rls_addr  out  AWIDTH  to mem_manager rls_block_addr.

Behaviour:
- Outputs are registered. On reset all outputs are 0; the FSM goes to IDLE; both round-robin pointers are 0.
- Reset mid-WAIT drops mm_ocp_req. The mem_manager is reset by the same rst_n, so no handshake is left dangling.
- Allocation FSM states:
  - IDLE: if (alloc_req != 0) and !mm_full, pick the winner as the first set bit of alloc_req at or after alloc_ptr, wrapping at NPORT-1 to 0. Latch the winner index, set mm_ocp_req=1 and alloc_busy=1, go to WAIT. If mm_full=1, no grant is made and requests stay pending.
  - WAIT: hold mm_ocp_req=1. On mm_ocp_rsp=1 && mm_ocp_vld=1:
    - clear mm_ocp_req at the same edge;
    - drive alloc_vld[winner]=1 and alloc_addr=mm_ocp_addr for exactly one cycle;
    - set alloc_ptr = winner+1 mod NPORT;
    - clear alloc_busy; go to DONE.
  - DONE: one cycle with mm_ocp_req=0, which guarantees the mem_manager returns to IDLE before the next grant. Go to IDLE.
- WAIT has no timeout. mm_full rising during WAIT does not cancel the request; the arbiter waits until mem_manager responds.
- Minimum alloc_req-to-alloc_vld latency is 4 cycles: grant, mem_manager IDLE->OCP, OCP rsp, output register. Back-to-back grant spacing is at least 5 cycles.
- The requester must deassert alloc_req[i] in the cycle after alloc_vld[i]. If it is still high, that is a new request; it is legal and is arbitrated fairly.
- A winner's alloc_req dropping during WAIT is a protocol violation. The block still completes, and the address is delivered on alloc_vld.
- Release path, independent of the allocation FSM; one release per cycle max:
  - Each cycle, if rls_req != 0, pick a winner round-robin from rls_ptr.
  - Next cycle: rls_ack[winner]=1, mm_rls_vld=1, mm_rls_addr=rls_addr slice of the winner; rls_ptr=winner+1.
  - A port's request is masked in the cycle its ack is out, so it is not double-counted.
  - Sustained throughput is 1 release per 2 cycles per port and 1 per cycle aggregate when 2 or more ports request.
- Simultaneous alloc and release, including a release and an alloc of the same address, both proceed. mem_manager handles the ordering.
- A release arriving while mm_full=1 is forwarded normally; it is how the allocator drains.

Test Plan:
- Single request: reset, alloc_req=4'b0001 with an empty mem_manager -> alloc_vld=4'b0001 after 4 cycles, alloc_addr=0, mm_ocp_req high exactly 2 cycles.
- Fairness: alloc_req=4'b1111 held, each port dropping its req one cycle after its vld and re-raising -> grant order 0,1,2,3,0; addresses 0,1,2,3,4 distinct.
- Full: fill all 2^AWIDTH blocks, then alloc_req=4'b0100 -> no grant while mm_full=1. Release block 5 via port 3 -> rls_ack=4'b1000, then alloc_vld=4'b0100 with alloc_addr=5.
- Release contention: rls_req=4'b0111 with addresses 10,11,12 the same cycle -> mm_rls_vld on 3 consecutive cycles with addresses 10,11,12, acks 0,1,2 one-hot in that order.
- Concurrent: port 1 alloc in WAIT while port 2 releases address 7 -> both complete; alloc latency unchanged.
- Reset mid-WAIT: assert rst_n=0 for 1 cycle during WAIT -> all outputs 0 next cycle; the next request is served from port 0 with a correct handshake.
